// File: rtl/prog_cmd_deframer.sv
// Collects 13-nibble programming frames (addr/op/data) into a small command FIFO for the executor.
// Build with PROG_OPCODE_CHK_EN defined to drop frames with unknown opcodes and pulse err_opcode.
module prog_cmd_deframer #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               prog_nibble_in,
  input  logic                     prog_nibble_in_valid,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [11:0]              cmd_addr,
  output logic [7:0]               cmd_op,
  output logic [31:0]              cmd_data,
  output logic                     frame_busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     err_abort,
  output logic                     err_overflow,
  output logic                     err_opcode
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0] LAST_IDX = 4'd12;
  localparam logic [7:0] OP_WRITE = 8'h02;
`ifdef PROG_OPCODE_CHK_EN
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_ADD   = 8'h10;
  localparam logic [7:0] OP_MUL   = 8'h12;
`endif

  // Frame assembly state
  logic [3:0]    r_cnt;
  logic [11:0]   r_addr;
  logic [7:0]    r_op;
  logic [27:0]   r_data_lo;

  // Command FIFO storage and pointers
  logic [11:0]   r_mem_addr [DEPTH];
  logic [7:0]    r_mem_op   [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          r_err_abort;
  logic          r_err_overflow;

  logic          w_last;
  logic          w_op_ok;
  logic [31:0]   w_frame_data;
  logic [31:0]   w_push_data;
  logic          w_push_req;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_overflow;
  logic          w_abort;

  assign w_last       = prog_nibble_in_valid && (r_cnt == LAST_IDX);
  assign w_abort      = !prog_nibble_in_valid && (r_cnt != 4'd0);
  // The final data nibble is used straight off the port so the frame can be pushed on its own edge.
  assign w_frame_data = {prog_nibble_in, r_data_lo};
  assign w_push_data  = (r_op == OP_WRITE) ? w_frame_data : 32'h0;

`ifdef PROG_OPCODE_CHK_EN
  logic r_err_opcode;
  assign w_op_ok = (r_op == OP_WRITE) || (r_op == OP_READ) ||
                   (r_op == OP_ADD)   || (r_op == OP_MUL);
  assign err_opcode = r_err_opcode;
`else
  assign w_op_ok    = 1'b1;
  assign err_opcode = 1'b0;
`endif

  // Handshake: a beat transfers on any rising edge where cmd_valid && cmd_ready are both high;
  // while cmd_valid is high and cmd_ready low, the head fields are held unchanged.
  assign w_push_req = w_last && w_op_ok;
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_pop      = cmd_valid && cmd_ready;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_overflow = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 4'd0;
      r_addr    <= 12'h0;
      r_op      <= 8'h0;
      r_data_lo <= 28'h0;
    end else if (prog_nibble_in_valid) begin
      r_cnt <= (r_cnt == LAST_IDX) ? 4'd0 : r_cnt + 4'd1;
      case (r_cnt)
        4'd0:    r_addr[3:0]  <= prog_nibble_in;
        4'd1:    r_addr[7:4]  <= prog_nibble_in;
        4'd2:    r_addr[11:8] <= prog_nibble_in;
        4'd3:    r_op[3:0]    <= prog_nibble_in;
        4'd4:    r_op[7:4]    <= prog_nibble_in;
        4'd12:   r_data_lo    <= r_data_lo;
        // idx 5..11 shift in from the top; after seven shifts idx 5 sits in data[3:0].
        default: r_data_lo    <= {prog_nibble_in, r_data_lo[27:4]};
      endcase
    end else begin
      r_cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_abort    <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_err_abort    <= w_abort;
      r_err_overflow <= w_overflow;
    end
  end

`ifdef PROG_OPCODE_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_opcode <= 1'b0;
    end else begin
      r_err_opcode <= w_last && !w_op_ok;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_addr[i] <= 12'h0;
        r_mem_op[i]   <= 8'h0;
        r_mem_data[i] <= 32'h0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem_addr[r_wr_ptr] <= r_addr;
        r_mem_op[r_wr_ptr]   <= r_op;
        r_mem_data[r_wr_ptr] <= w_push_data;
        r_wr_ptr             <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign cmd_valid    = (r_count != '0);
  assign cmd_addr     = cmd_valid ? r_mem_addr[r_rd_ptr] : 12'h0;
  assign cmd_op       = cmd_valid ? r_mem_op[r_rd_ptr]   : 8'h0;
  assign cmd_data     = cmd_valid ? r_mem_data[r_rd_ptr] : 32'h0;
  assign frame_busy   = (r_cnt != 4'd0);
  assign fifo_count   = r_count;
  assign err_abort    = r_err_abort;
  assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_prog_cmd_deframer.sv
// Directed bench for prog_cmd_deframer: hand-computed frames, beat scoreboard, error pulse counts.
module tb_prog_cmd_deframer;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    prog_nibble_in;
  logic          prog_nibble_in_valid;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [11:0]   cmd_addr;
  logic [7:0]    cmd_op;
  logic [31:0]   cmd_data;
  logic          frame_busy;
  logic [CW-1:0] fifo_count;
  logic          err_abort;
  logic          err_overflow;
  logic          err_opcode;

  int total = 0;
  int bad   = 0;
  int n_abort = 0;
  int n_ovf   = 0;
  int n_opc   = 0;

  // Entries are {addr, op, data}
  logic [51:0] exp_q[$];
  logic [51:0] got_q[$];

  prog_cmd_deframer #(.DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .prog_nibble_in       (prog_nibble_in),
    .prog_nibble_in_valid (prog_nibble_in_valid),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_addr             (cmd_addr),
    .cmd_op               (cmd_op),
    .cmd_data             (cmd_data),
    .frame_busy           (frame_busy),
    .fifo_count           (fifo_count),
    .err_abort            (err_abort),
    .err_overflow         (err_overflow),
    .err_opcode           (err_opcode)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (err_abort === 1'b1)    n_abort++;
      if (err_overflow === 1'b1) n_ovf++;
      if (err_opcode === 1'b1)   n_opc++;
      if (cmd_valid === 1'b1 && cmd_ready === 1'b1)
        got_q.push_back({cmd_addr, cmd_op, cmd_data});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nib(input logic [3:0] n);
    prog_nibble_in       = n;
    prog_nibble_in_valid = 1'b1;
    step();
  endtask

  task automatic idle(input int n);
    prog_nibble_in       = 4'h0;
    prog_nibble_in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_frame(input logic [11:0] a, input logic [7:0] op, input logic [31:0] d);
    logic [51:0] f;
    f = {d, op, a};
    for (int i = 0; i < 13; i++) nib(f[4*i +: 4]);
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int k;
    k = 0;
    while (fifo_count != '0 && k < budget) begin
      step();
      k++;
    end
    chk(tag, 64'(fifo_count), 64'd0);
  endtask

  task automatic check_beats(input string tag);
    chk({tag, "_nbeats"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() != 0 && exp_q.size() != 0)
      chk({tag, "_beat"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int a0, o0, p0;
    rst_n                = 1'b0;
    prog_nibble_in       = 4'h0;
    prog_nibble_in_valid = 1'b0;
    cmd_ready            = 1'b0;
    repeat (3) step();

    // Reset values
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_cmd_addr",  64'(cmd_addr),  64'd0);
    chk("rst_cmd_op",    64'(cmd_op),    64'd0);
    chk("rst_cmd_data",  64'(cmd_data),  64'd0);
    chk("rst_busy",      64'(frame_busy), 64'd0);
    chk("rst_count",     64'(fifo_count), 64'd0);
    chk("rst_errs",      64'({err_abort, err_overflow, err_opcode}), 64'd0);
    rst_n = 1'b1;
    step();

    // Reset asserted mid-frame discards the partial frame
    for (int i = 0; i < 5; i++) nib(4'(i + 3));
    chk("busy_midframe", 64'(frame_busy), 64'd1);
    prog_nibble_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("busy_async_rst", 64'(frame_busy), 64'd0);
    step();
    rst_n = 1'b1;

    // WRITE frame 0,F,0,2,0,8,7,6,5,4,3,2,1 with ready high
    cmd_ready = 1'b1;
    send_frame(12'h0F0, 8'h02, 32'h12345678);
    exp_q.push_back({12'h0F0, 8'h02, 32'h12345678});
    chk("wr_valid_lat", 64'(cmd_valid), 64'd1);
    chk("wr_count",     64'(fifo_count), 64'd1);
    chk("wr_busy_done", 64'(frame_busy), 64'd0);
    chk("wr_head",      64'({cmd_addr, cmd_op, cmd_data}), 64'({12'h0F0, 8'h02, 32'h12345678}));
    idle(2);
    chk("wr_count_back", 64'(fifo_count), 64'd0);
    check_beats("write");

    // ADD frame with X operand nibbles: operand must come out as zero
    send_frame(12'h0F0, 8'h10, 32'hxxxxxxxx);
    exp_q.push_back({12'h0F0, 8'h10, 32'h0});
    chk("add_data_nox", 64'(cmd_data), 64'd0);
    chk("add_op",       64'(cmd_op),   64'h10);
    idle(2);
    check_beats("add");

    // Abort after 6 nibbles, then full READ frame
    a0 = n_abort;
    for (int i = 0; i < 6; i++) nib(4'hA);
    chk("abort_busy", 64'(frame_busy), 64'd1);
    idle(1);
    chk("abort_pulse", 64'(err_abort), 64'd1);
    send_frame(12'h0F2, 8'h03, 32'h87654321);
    exp_q.push_back({12'h0F2, 8'h03, 32'h0});
    idle(3);
    chk("abort_count", 64'(n_abort - a0), 64'd1);
    check_beats("read");

    // Overflow: ready low, three back-to-back WRITE frames
    cmd_ready = 1'b0;
    o0 = n_ovf;
    send_frame(12'h101, 8'h02, 32'hAAAA0001);
    send_frame(12'h202, 8'h02, 32'hBBBB0002);
    send_frame(12'h303, 8'h02, 32'hCCCC0003);
    exp_q.push_back({12'h101, 8'h02, 32'hAAAA0001});
    exp_q.push_back({12'h202, 8'h02, 32'hBBBB0002});
    chk("ovf_pulse", 64'(err_overflow), 64'd1);
    chk("ovf_count", 64'(fifo_count), 64'd2);
    idle(1);
    chk("ovf_head",   64'({cmd_addr, cmd_op, cmd_data}), 64'({12'h101, 8'h02, 32'hAAAA0001}));
    idle(3);
    chk("ovf_hold",   64'({cmd_addr, cmd_op, cmd_data}), 64'({12'h101, 8'h02, 32'hAAAA0001}));
    chk("ovf_npulse", 64'(n_ovf - o0), 64'd1);
    cmd_ready = 1'b1;
    wait_empty("ovf_drain", 20);
    cmd_ready = 1'b0;
    check_beats("ovf");

    // Full FIFO with a pop on the same edge as idx 12: push accepted
    o0 = n_ovf;
    send_frame(12'h411, 8'h02, 32'h11112222);
    send_frame(12'h422, 8'h12, 32'hFFFFFFFF);
    begin
      logic [51:0] f;
      f = {32'h33334444, 8'h02, 12'h433};
      for (int i = 0; i < 12; i++) nib(f[4*i +: 4]);
      cmd_ready = 1'b1;
      nib(f[51:48]);
      cmd_ready = 1'b0;
    end
    exp_q.push_back({12'h411, 8'h02, 32'h11112222});
    exp_q.push_back({12'h422, 8'h12, 32'h0});
    exp_q.push_back({12'h433, 8'h02, 32'h33334444});
    chk("fullpop_count", 64'(fifo_count), 64'd2);
    chk("fullpop_noovf", 64'(err_overflow), 64'd0);
    chk("fullpop_head",  64'({cmd_addr, cmd_op, cmd_data}), 64'({12'h422, 8'h12, 32'h0}));
    idle(2);
    chk("fullpop_novf_n", 64'(n_ovf - o0), 64'd0);
    cmd_ready = 1'b1;
    wait_empty("fullpop_drain", 20);
    cmd_ready = 1'b0;
    check_beats("fullpop");

    // Illegal opcode 0x55
    p0 = n_opc;
    send_frame(12'h555, 8'h55, 32'hDEADBEEF);
`ifdef PROG_OPCODE_CHK_EN
    chk("opc_pulse", 64'(err_opcode), 64'd1);
    chk("opc_count", 64'(fifo_count), 64'd0);
    idle(2);
    chk("opc_npulse", 64'(n_opc - p0), 64'd1);
`else
    exp_q.push_back({12'h555, 8'h55, 32'h0});
    chk("opc_count", 64'(fifo_count), 64'd1);
    chk("opc_head",  64'({cmd_addr, cmd_op, cmd_data}), 64'({12'h555, 8'h55, 32'h0}));
    idle(2);
    chk("opc_npulse", 64'(n_opc - p0), 64'd0);
    cmd_ready = 1'b1;
    wait_empty("opc_drain", 20);
    cmd_ready = 1'b0;
`endif
    idle(2);
    check_beats("opcode");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
